// File: rtl/rob.sv
// rob: reorder buffer that retires out-of-order completed results strictly in allocation order and flushes on a mispredicted branch.
// Latency: a CDB completion is latched first, so the earliest commit pulse is one edge later; commit and flush outputs are registered.
// Backpressure: full_out blocks allocation (even when a commit happens in the same cycle); rdy_in low freezes every state bit and output.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global advance enable)
//   dec_*   : allocation request from the decoder; full_out / alloc_tag_out report capacity and the tag to be handed out
//   cdb_*   : completion broadcast (tag, value, actual branch outcome)
//   commit_*: one-cycle commit pulse with destination, value and entry tag
//   need_flush_out / flush_pc_out: one-cycle mispredict flush with redirect PC
//   q_tag_in / q_ready_out / q_value_out: operand query port, only active when ROB_QUERY_EN is defined
//
// Build option: define ROB_QUERY_EN to enable the combinational operand query port (with CDB bypass).
// Without it the query outputs are tied to zero.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif
`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif

module rob #(
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH,
  parameter int REG_NUM_WIDTH  = `REG_NUM_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,

  input  logic                      dec_valid_in,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd_in,
  input  logic                      dec_is_br_in,
  input  logic                      dec_pred_jump_in,
  input  logic [31:0]               dec_alt_pc_in,
  output logic                      full_out,
  output logic [ROB_SIZE_WIDTH-1:0] alloc_tag_out,

  input  logic                      cdb_valid_in,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag_in,
  input  logic [31:0]               cdb_value_in,
  input  logic                      cdb_jump_in,

  output logic                      commit_valid_out,
  output logic [REG_NUM_WIDTH-1:0]  commit_rd_out,
  output logic [31:0]               commit_value_out,
  output logic [ROB_SIZE_WIDTH-1:0] commit_tag_out,

  output logic                      need_flush_out,
  output logic [31:0]               flush_pc_out,

  input  logic [ROB_SIZE_WIDTH-1:0] q_tag_in,
  output logic                      q_ready_out,
  output logic [31:0]               q_value_out
);

  localparam int SIZE = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_FULL = (ROB_SIZE_WIDTH+1)'(SIZE);
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE  = ROB_SIZE_WIDTH'(1);
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ZERO = '0;

  // Control state: pointers, occupancy and per-entry busy/ready flags (reset).
  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [ROB_SIZE_WIDTH:0]   count;
  logic [SIZE-1:0]           busy;
  logic [SIZE-1:0]           ready;

  // Payload storage: only meaningful while the matching busy bit is set,
  // so it is left out of the reset domain.
  logic [REG_NUM_WIDTH-1:0]  rd_mem     [SIZE];
  logic [31:0]               value_mem  [SIZE];
  logic [31:0]               alt_pc_mem [SIZE];
  logic [SIZE-1:0]           is_br_mem;
  logic [SIZE-1:0]           pred_mem;
  logic [SIZE-1:0]           jump_mem;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;
  logic mispredict;

  assign full_out      = (count == CNT_FULL);
  assign alloc_tag_out = tail;

  // The cycle in which need_flush_out is high belongs to the flush: nothing
  // new enters, completes or retires until the front end has redirected.
  assign alloc_fire  = dec_valid_in && !full_out && !need_flush_out;
  assign cdb_fire    = cdb_valid_in && busy[cdb_tag_in] && !need_flush_out;
  // Commit looks only at the registered ready bit, so a CDB hit on the head
  // entry retires one edge later rather than combinationally.
  assign commit_fire = busy[head] && ready[head] && !need_flush_out;
  assign mispredict  = commit_fire && is_br_mem[head] && (jump_mem[head] != pred_mem[head]);

  // Pointer, occupancy, flag and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= CNT_ZERO;
      busy             <= '0;
      ready            <= '0;
      commit_valid_out <= 1'b0;
      commit_rd_out    <= '0;
      commit_value_out <= '0;
      commit_tag_out   <= '0;
      need_flush_out   <= 1'b0;
      flush_pc_out     <= '0;
    end else if (rdy_in) begin
      commit_valid_out <= commit_fire;
      need_flush_out   <= mispredict;

      if (commit_fire) begin
        commit_rd_out    <= rd_mem[head];
        commit_value_out <= value_mem[head];
        commit_tag_out   <= head;
      end

      if (mispredict) begin
        // The mispredicted branch itself still retires; everything younger
        // is squashed and the buffer restarts empty at index 0.
        flush_pc_out <= alt_pc_mem[head];
        busy         <= '0;
        ready        <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= CNT_ZERO;
      end else begin
        // Allocation can never hit the head slot being retired: tail == head
        // with an entry to retire means the buffer is full, which blocks
        // allocation. A CDB hit on the retiring head is overridden below.
        if (alloc_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + PTR_ONE;
        end
        if (cdb_fire) begin
          ready[cdb_tag_in] <= 1'b1;
        end
        if (commit_fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + PTR_ONE;
        end
        count <= count + (ROB_SIZE_WIDTH+1)'(alloc_fire) - (ROB_SIZE_WIDTH+1)'(commit_fire);
      end
    end
  end

  // Entry payload writes. An allocation in the flush cycle is squashed by the
  // control logic (busy stays clear), so the stray payload write is harmless.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (alloc_fire) begin
        rd_mem[tail]     <= dec_rd_in;
        alt_pc_mem[tail] <= dec_alt_pc_in;
        is_br_mem[tail]  <= dec_is_br_in;
        pred_mem[tail]   <= dec_pred_jump_in;
      end
      if (cdb_fire) begin
        value_mem[cdb_tag_in] <= cdb_value_in;
        jump_mem[cdb_tag_in]  <= cdb_jump_in;
      end
    end
  end

`ifdef ROB_QUERY_EN
  // Operand query: a stored completed value wins; otherwise a CDB broadcast
  // for the same entry in this cycle is forwarded so a consumer issuing now
  // does not miss the result.
  always_comb begin
    q_ready_out = 1'b0;
    q_value_out = '0;
    if (busy[q_tag_in] && ready[q_tag_in]) begin
      q_ready_out = 1'b1;
      q_value_out = value_mem[q_tag_in];
    end else if (cdb_fire && (cdb_tag_in == q_tag_in)) begin
      q_ready_out = 1'b1;
      q_value_out = cdb_value_in;
    end
  end
`else
  logic unused_q_tag;
  assign unused_q_tag = ^q_tag_in;
  assign q_ready_out  = 1'b0;
  assign q_value_out  = '0;
`endif

endmodule

// File: tb/tb_rob.sv
// tb_rob: directed stimulus for the reorder buffer, checked every cycle against a queue-based model of in-order retirement.
// Latency: model predicts registered commit/flush outputs one edge after the inputs that cause them.
// Backpressure: exercises full-buffer blocking, flush-cycle blocking and rdy_in stalls.

module tb_rob;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_valid_in;
  logic [4:0]  dec_rd_in;
  logic        dec_is_br_in;
  logic        dec_pred_jump_in;
  logic [31:0] dec_alt_pc_in;
  logic        full_out;
  logic [2:0]  alloc_tag_out;
  logic        cdb_valid_in;
  logic [2:0]  cdb_tag_in;
  logic [31:0] cdb_value_in;
  logic        cdb_jump_in;
  logic        commit_valid_out;
  logic [4:0]  commit_rd_out;
  logic [31:0] commit_value_out;
  logic [2:0]  commit_tag_out;
  logic        need_flush_out;
  logic [31:0] flush_pc_out;
  logic [2:0]  q_tag_in;
  logic        q_ready_out;
  logic [31:0] q_value_out;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid_in(dec_valid_in), .dec_rd_in(dec_rd_in), .dec_is_br_in(dec_is_br_in),
    .dec_pred_jump_in(dec_pred_jump_in), .dec_alt_pc_in(dec_alt_pc_in),
    .full_out(full_out), .alloc_tag_out(alloc_tag_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .cdb_jump_in(cdb_jump_in),
    .commit_valid_out(commit_valid_out), .commit_rd_out(commit_rd_out),
    .commit_value_out(commit_value_out), .commit_tag_out(commit_tag_out),
    .need_flush_out(need_flush_out), .flush_pc_out(flush_pc_out),
    .q_tag_in(q_tag_in), .q_ready_out(q_ready_out), .q_value_out(q_value_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Model: program-order queue of in-flight instructions.
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic        is_br;
    logic        pred;
    logic        jump;
    logic        ready;
    logic [31:0] alt_pc;
    logic [31:0] value;
  } ent_t;

  ent_t        mq[$];
  int          next_tag;
  logic        exp_cv;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val;
  logic [2:0]  exp_tag;
  logic        exp_flush;
  logic [31:0] exp_fpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    next_tag  = 0;
    exp_cv    = 1'b0;
    exp_rd    = '0;
    exp_val   = '0;
    exp_tag   = '0;
    exp_flush = 1'b0;
    exp_fpc   = '0;
  endtask

  // Effect of one rising edge given the inputs applied before it.
  task automatic model_step();
    logic com;
    logic alc;
    logic mis;
    ent_t e;
    if (!rdy_in) return;
    com = !exp_flush && (mq.size() > 0) && mq[0].ready;
    alc = dec_valid_in && (mq.size() < 8) && !exp_flush;
    mis = com && mq[0].is_br && (mq[0].jump != mq[0].pred);
    exp_cv = com;
    if (com) begin
      exp_rd  = mq[0].rd;
      exp_val = mq[0].value;
      exp_tag = mq[0].tag;
    end
    if (mis) begin
      exp_fpc   = mq[0].alt_pc;
      exp_flush = 1'b1;
      mq.delete();
      next_tag  = 0;
    end else begin
      if (!exp_flush && cdb_valid_in) begin
        foreach (mq[i]) begin
          if (mq[i].tag == cdb_tag_in) begin
            mq[i].ready = 1'b1;
            mq[i].value = cdb_value_in;
            mq[i].jump  = cdb_jump_in;
          end
        end
      end
      exp_flush = 1'b0;
      if (com) void'(mq.pop_front());
      if (alc) begin
        e.tag    = 3'(next_tag);
        e.rd     = dec_rd_in;
        e.is_br  = dec_is_br_in;
        e.pred   = dec_pred_jump_in;
        e.jump   = 1'b0;
        e.ready  = 1'b0;
        e.alt_pc = dec_alt_pc_in;
        e.value  = '0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % 8;
      end
    end
  endtask

  task automatic compare_all();
    logic        qr;
    logic [31:0] qv;
    check("full_out", 32'(full_out), (mq.size() == 8) ? 1 : 0);
    check("alloc_tag_out", 32'(alloc_tag_out), 32'(next_tag));
    check("commit_valid_out", 32'(commit_valid_out), 32'(exp_cv));
    if (exp_cv) begin
      check("commit_rd_out", 32'(commit_rd_out), 32'(exp_rd));
      check("commit_value_out", commit_value_out, exp_val);
      check("commit_tag_out", 32'(commit_tag_out), 32'(exp_tag));
    end
    check("need_flush_out", 32'(need_flush_out), 32'(exp_flush));
    if (exp_flush) check("flush_pc_out", flush_pc_out, exp_fpc);
    qr = 1'b0;
    qv = '0;
`ifdef ROB_QUERY_EN
    foreach (mq[i]) begin
      if (mq[i].tag == q_tag_in) begin
        if (mq[i].ready) begin
          qr = 1'b1;
          qv = mq[i].value;
        end else if (cdb_valid_in && (cdb_tag_in == q_tag_in) && !exp_flush) begin
          qr = 1'b1;
          qv = cdb_value_in;
        end
      end
    end
`endif
    check("q_ready_out", 32'(q_ready_out), 32'(qr));
    check("q_value_out", q_value_out, qv);
  endtask

  always @(negedge clk_in) begin
    if (chk_en) compare_all();
  end

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
    dec_valid_in = 1'b1; dec_rd_in = rd; dec_is_br_in = br;
    dec_pred_jump_in = pred; dec_alt_pc_in = alt;
    cyc();
    dec_valid_in = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] val, input logic jmp);
    cdb_valid_in = 1'b1; cdb_tag_in = tag; cdb_value_in = val; cdb_jump_in = jmp;
    cyc();
    cdb_valid_in = 1'b0;
  endtask

  // Called #1 after a rising edge.
  task automatic do_reset();
    chk_en = 1'b0;
    dec_valid_in = 1'b0;
    cdb_valid_in = 1'b0;
    rdy_in = 1'b1;
    rst_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    dec_valid_in = 1'b0; dec_rd_in = '0; dec_is_br_in = 1'b0;
    dec_pred_jump_in = 1'b0; dec_alt_pc_in = '0;
    cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_value_in = '0; cdb_jump_in = 1'b0;
    q_tag_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset commit_valid", 32'(commit_valid_out), 0);
    check("reset need_flush", 32'(need_flush_out), 0);
    check("reset full", 32'(full_out), 0);
    check("reset alloc_tag", 32'(alloc_tag_out), 0);
    check("reset flush_pc", flush_pc_out, 0);
    rst_in = 1'b1;
    chk_en = 1'b1;

    // Basic allocate / complete / commit.
    alloc(5'd5, 1'b0, 1'b0, 32'h0);
    cdb(3'd0, 32'h1234, 1'b0);
    cyc();
    check("basic commit_valid", 32'(commit_valid_out), 1);
    check("basic commit_rd", 32'(commit_rd_out), 5);
    check("basic commit_value", commit_value_out, 32'h1234);
    check("basic commit_tag", 32'(commit_tag_out), 0);
    cyc();
    check("basic pulse drops", 32'(commit_valid_out), 0);

    // Fill to capacity, overflow request, wrap of the tag.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 1'b0, 1'b0, 32'h0);
    check("fill full_out", 32'(full_out), 1);
    check("fill alloc_tag", 32'(alloc_tag_out), 0);
    alloc(5'd31, 1'b0, 1'b0, 32'h0);
    cdb(3'd0, 32'hA0, 1'b0);
    dec_valid_in = 1'b1; dec_rd_in = 5'd9;
    cyc();
    check("full commit_tag", 32'(commit_tag_out), 0);
    check("full commit_rd", 32'(commit_rd_out), 1);
    check("full commit_value", commit_value_out, 32'hA0);
    check("full blocks alloc", 32'(full_out), 0);
    check("wrap alloc_tag", 32'(alloc_tag_out), 0);
    cyc();
    dec_valid_in = 1'b0;
    check("wrap refill full", 32'(full_out), 1);
    check("wrap next tag", 32'(alloc_tag_out), 1);
    cdb(3'd1, 32'hB1, 1'b0);
    dec_valid_in = 1'b1; dec_rd_in = 5'd10;
    cyc();
    dec_valid_in = 1'b0;
    cyc();

    // Mispredicted branch at the head.
    do_reset();
    alloc(5'd0, 1'b1, 1'b0, 32'h100);
    alloc(5'd2, 1'b0, 1'b0, 32'h0);
    alloc(5'd3, 1'b0, 1'b0, 32'h0);
    cdb(3'd0, 32'h0, 1'b1);
    cyc();
    check("flush need_flush", 32'(need_flush_out), 1);
    check("flush pc", flush_pc_out, 32'h100);
    check("flush commit_valid", 32'(commit_valid_out), 1);
    check("flush commit_tag", 32'(commit_tag_out), 0);
    dec_valid_in = 1'b1; dec_rd_in = 5'd8;
    cdb_valid_in = 1'b1; cdb_tag_in = 3'd1; cdb_value_in = 32'h55;
    cyc();
    dec_valid_in = 1'b0; cdb_valid_in = 1'b0;
    check("post flush need_flush", 32'(need_flush_out), 0);
    check("post flush commit_valid", 32'(commit_valid_out), 0);
    check("post flush alloc_tag", 32'(alloc_tag_out), 0);
    alloc(5'd7, 1'b0, 1'b0, 32'h0);
    check("post flush second tag", 32'(alloc_tag_out), 1);

    // Out-of-order completion, in-order retirement, rdy_in stalls.
    do_reset();
    alloc(5'd1, 1'b0, 1'b0, 32'h0);
    alloc(5'd2, 1'b0, 1'b0, 32'h0);
    alloc(5'd3, 1'b0, 1'b0, 32'h0);
    cdb(3'd2, 32'h22, 1'b0);
    cdb(3'd1, 32'h11, 1'b0);
    cdb(3'd0, 32'h10, 1'b0);
    cyc();
    check("order 1st tag", 32'(commit_tag_out), 0);
    check("order 1st value", commit_value_out, 32'h10);
    cyc();
    check("order 2nd tag", 32'(commit_tag_out), 1);
    check("order 2nd valid", 32'(commit_valid_out), 1);
    cyc();
    check("order 3rd tag", 32'(commit_tag_out), 2);
    check("order 3rd value", commit_value_out, 32'h22);
    alloc(5'd4, 1'b0, 1'b0, 32'h0);
    cdb(3'd3, 32'h33, 1'b0);
    rdy_in = 1'b0;
    repeat (3) cyc();
    check("stall no commit", 32'(commit_valid_out), 0);
    rdy_in = 1'b1;
    cyc();
    check("stall release commit", 32'(commit_valid_out), 1);
    check("stall release tag", 32'(commit_tag_out), 3);
    rdy_in = 1'b0;
    repeat (2) cyc();
    check("stall holds pulse", 32'(commit_valid_out), 1);
    rdy_in = 1'b1;
    cyc();
    check("pulse not reissued", 32'(commit_valid_out), 0);
    alloc(5'd6, 1'b1, 1'b1, 32'h200);
    cdb(3'd4, 32'h44, 1'b1);
    cyc();
    check("good branch commit", 32'(commit_valid_out), 1);
    check("good branch no flush", 32'(need_flush_out), 0);
    check("good branch value", commit_value_out, 32'h44);
    cyc();

    // Query port and asynchronous reset mid-commit.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 11), 1'b0, 1'b0, 32'h0);
    q_tag_in = 3'd3;
    cdb_valid_in = 1'b1; cdb_tag_in = 3'd3; cdb_value_in = 32'd7; cdb_jump_in = 1'b0;
    #1;
`ifdef ROB_QUERY_EN
    check("query bypass ready", 32'(q_ready_out), 1);
    check("query bypass value", q_value_out, 7);
`else
    check("query off ready", 32'(q_ready_out), 0);
    check("query off value", q_value_out, 0);
`endif
    cyc();
    cdb_valid_in = 1'b0;
    cdb(3'd0, 32'h99, 1'b0);
    cyc();
    check("pre reset commit", 32'(commit_valid_out), 1);
    chk_en = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check("async commit_valid", 32'(commit_valid_out), 0);
    check("async commit_rd", 32'(commit_rd_out), 0);
    check("async commit_value", commit_value_out, 0);
    check("async commit_tag", 32'(commit_tag_out), 0);
    check("async need_flush", 32'(need_flush_out), 0);
    check("async flush_pc", flush_pc_out, 0);
    check("async alloc_tag", 32'(alloc_tag_out), 0);
    check("async full", 32'(full_out), 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    chk_en = 1'b1;
    alloc(5'd1, 1'b0, 1'b0, 32'h0);
    check("after reset tag", 32'(alloc_tag_out), 1);
    cyc();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
